// File: rtl/uart_tx_rx_ctrl_if.sv
// rtl/uart_tx_rx_ctrl_if.sv - handshake and serial signal bundle for the 8N1 UART controller
interface uart_tx_rx_ctrl_if;
    logic       SEND;
    logic [7:0] DATA;
    logic       READY;
    logic       UART_TX;
    logic       UART_RX;
    logic [7:0] RECV_DATA;
    logic       VALID;

    modport master (
        output SEND,
        output DATA,
        output UART_RX,
        input  READY,
        input  UART_TX,
        input  RECV_DATA,
        input  VALID
    );

    modport slave (
        input  SEND,
        input  DATA,
        input  UART_RX,
        output READY,
        output UART_TX,
        output RECV_DATA,
        output VALID
    );
endinterface

// File: rtl/uart_tx_rx_ctrl.sv
// rtl/uart_tx_rx_ctrl.sv - independent 8N1 UART transmit and receive controllers
module uart_tx_rx_ctrl #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_rx_ctrl_if.slave  bus
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    // ---------------- transmitter state ----------------
    logic [0:0]    tx_state_q, tx_state_d;
    logic [8:0]    tx_shift_q, tx_shift_d;   // {stop, D7..D0}; start bit goes straight to the output flop
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [3:0]    tx_bit_q,   tx_bit_d;
    logic          tx_out_q,   tx_out_d;

    // ---------------- receiver state ----------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic          rx_prev_q,  rx_prev_d;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [3:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_byte_q,  rx_byte_d;
    logic [7:0]    rx_data_q,  rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_s;

    assign rx_s          = sync_q[SYNC_STAGES-1];
    assign bus.READY     = (tx_state_q == TX_IDLE);
    assign bus.UART_TX   = tx_out_q;
    assign bus.RECV_DATA = rx_data_q;
    assign bus.VALID     = rx_valid_q;

    // TX: accept a byte when idle, then hold each of the 10 bits for one full bit period
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_timer_d = tx_timer_q;
        tx_bit_d   = tx_bit_q;
        tx_out_d   = tx_out_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_out_d = 1'b1;
                if (bus.SEND) begin
                    tx_shift_d = {1'b1, bus.DATA};
                    tx_timer_d = '0;
                    tx_bit_d   = 4'd0;
                    tx_out_d   = 1'b0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_timer_q == T_LAST) begin
                    tx_timer_d = '0;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) begin
                        tx_out_d   = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_out_d   = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_out_d   = 1'b1;
            end
        endcase
    end

    // RX: synchronise the line, find the start edge, then sample every bit at its midpoint
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.UART_RX};
        rx_prev_d  = rx_s;
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_timer_d = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_timer_q == T_HALF) begin
                    rx_timer_d = '0;
                    rx_bit_d   = 4'd0;
                    // a line already back high at mid start bit was only a glitch
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (rx_timer_q == T_LAST) begin
                    rx_timer_d = '0;
                    rx_byte_d  = {rx_s, rx_byte_q[7:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_STOP: begin
                if (rx_timer_q == T_LAST) begin
                    rx_timer_d = '0;
                    if (rx_s) begin
                        rx_data_d  = rx_byte_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + TW'(1);
                end
            end
            RX_WAIT: begin
                // framing error: hold off until the line idles high again
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // state registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_timer_q <= '0;
            tx_bit_q   <= 4'd0;
            tx_out_q   <= 1'b1;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_bit_q   <= 4'd0;
            rx_byte_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_out_q   <= tx_out_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_rx_ctrl.sv
// tb/tb_uart_tx_rx_ctrl.sv - directed self-checking bench for uart_tx_rx_ctrl
module tb_uart_tx_rx_ctrl;

    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic loop_en;
    logic rx_drv;
    int   checks;
    int   errors;
    logic [7:0] rx_log[$];

    uart_tx_rx_ctrl_if bus();

    assign bus.UART_RX = loop_en ? bus.UART_TX : rx_drv;

    uart_tx_rx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // record every received byte, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.VALID === 1'b1) begin
            rx_log.push_back(bus.RECV_DATA);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // waits at negedges for READY, bounded; returns 1 when seen
    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (bus.READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // drive one frame directly onto the receive line
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        wait_cyc(CPB);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            wait_cyc(CPB);
        end
        rx_drv = stop_bit;
        wait_cyc(CPB);
        rx_drv = 1'b1;
    endtask

    task automatic send_pulse(input logic [7:0] b);
        bus.SEND = 1'b1;
        bus.DATA = b;
        @(posedge clk);
        @(negedge clk);
        bus.SEND = 1'b0;
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] str [8];
        time        acc_t [8];
        int         low_cnt;
        logic       ok;

        checks   = 0;
        errors   = 0;
        loop_en  = 1'b1;
        rx_drv   = 1'b1;
        bus.SEND = 1'b0;
        bus.DATA = 8'h00;
        rst      = 1'b1;

        // 1: reset values
        wait_cyc(2);
        chk("rst_tx", {31'd0, bus.UART_TX}, 32'd1);
        chk("rst_ready", {31'd0, bus.READY}, 32'd1);
        chk("rst_valid", {31'd0, bus.VALID}, 32'd0);
        chk("rst_recv", {24'd0, bus.RECV_DATA}, 32'h00);
        rst = 1'b0;
        wait_cyc(3);

        // 2: single byte 0x41, bit-by-bit line check and READY timing
        frame   = {1'b1, 8'h41, 1'b0};
        low_cnt = 0;
        rx_log.delete();
        send_pulse(8'h41);
        for (int i = 0; i <= 160; i++) begin
            if (i < 160 && bus.READY === 1'b0) low_cnt++;
            if ((i % CPB) == CPB / 2) begin
                chk($sformatf("tx_bit%0d", i / CPB), {31'd0, bus.UART_TX}, {31'd0, frame[i / CPB]});
            end
            if (i < 160) @(negedge clk);
        end
        chk("ready_low_cycles", low_cnt, 160);
        chk("ready_back", {31'd0, bus.READY}, 32'd1);
        wait_cyc(30);
        chk("single_count", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("single_data", {24'd0, rx_log[0]}, 32'h41);

        // 3: string with SEND held high
        str[0] = 8'h41; str[1] = 8'h52; str[2] = 8'h54; str[3] = 8'h59;
        str[4] = 8'h20; str[5] = 8'h41; str[6] = 8'h37; str[7] = 8'h0A;
        rx_log.delete();
        bus.SEND = 1'b1;
        bus.DATA = str[0];
        for (int i = 0; i < 8; i++) begin
            wait_ready(ok);
            if (!ok) chk($sformatf("str_ready_timeout%0d", i), 32'd0, 32'd1);
            acc_t[i] = $time;
            @(posedge clk);
            @(negedge clk);
            if (i < 7) bus.DATA = str[i + 1];
        end
        bus.SEND = 1'b0;
        wait_cyc(200);
        chk("str_count", rx_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_log.size()) chk($sformatf("str_byte%0d", i), {24'd0, rx_log[i]}, {24'd0, str[i]});
        end
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("str_gap%0d", i), 32'((acc_t[i] - acc_t[i - 1]) / 10), 32'd161);
        end

        // 4: DATA changes mid-frame
        rx_log.delete();
        send_pulse(8'h59);
        wait_cyc(80);
        bus.DATA = 8'hFF;
        wait_cyc(150);
        chk("stable_count", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("stable_data", {24'd0, rx_log[0]}, 32'h59);

        // 5: receiver robustness with the line driven directly
        rx_log.delete();
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        wait_cyc(5);
        rx_drv = 1'b0;
        wait_cyc(4);
        rx_drv = 1'b1;
        wait_cyc(40);
        chk("glitch_count", rx_log.size(), 0);
        send_rx(8'h3C, 1'b0);
        wait_cyc(40);
        chk("frame_err_count", rx_log.size(), 0);
        chk("frame_err_hold", {24'd0, bus.RECV_DATA}, 32'h59);
        send_rx(8'hA5, 1'b1);
        wait_cyc(20);
        chk("good_count", rx_log.size(), 1);
        chk("good_data", {24'd0, bus.RECV_DATA}, 32'hA5);

        // 6: reset during data bit 4 of a transmitted frame
        loop_en = 1'b1;
        wait_cyc(5);
        rx_log.delete();
        send_pulse(8'h41);
        wait_cyc(88);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", {31'd0, bus.UART_TX}, 32'd1);
        chk("midrst_ready", {31'd0, bus.READY}, 32'd1);
        rst = 1'b0;
        wait_cyc(200);
        chk("midrst_no_valid", rx_log.size(), 0);
        send_pulse(8'h0A);
        wait_cyc(200);
        chk("after_rst_count", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("after_rst_data", {24'd0, rx_log[0]}, 32'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
